// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter state encoding, tag base byte,
// default bit period and the 7-segment hex glyphs used by display blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } arb_state_e;

    localparam logic [7:0] TAG_BASE   = 8'hA0;
    localparam int         BIT_PERIOD = 1250;

    // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit searching
// upward, circularly, starting one past the pointer.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] sel_o,
    output logic           valid_o
);

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        int idx;
        sel_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[IDW'(idx)]) begin
                sel_o   = IDW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx engine between N_REQ byte sources.
// Define UART_ARB_TAG_EN to prefix every data byte with a tag byte (TAG_BASE | id).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = BIT_PERIOD,
    parameter int ACCEPT_TIMEOUT = 8
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       data,
    output logic [N_REQ-1:0]         ack,
    output logic                     tx_start,
    output logic [7:0]               tx_byte,
    input  logic                     tx_busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active,
    output logic [7:0]               byte_count,
    output logic                     err
);

    localparam int IDW      = $clog2(N_REQ);
    localparam int CNT_MAX  = (GAP_CYCLES > ACCEPT_TIMEOUT) ? GAP_CYCLES : ACCEPT_TIMEOUT;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             start_q, start_d;
    logic [7:0]       byte_q, byte_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [7:0]       count_q, count_d;
    logic             err_q, err_d;
`ifdef UART_ARB_TAG_EN
    logic             tag_q, tag_d;
    logic [7:0]       hold_q, hold_d;
`endif

    logic [IDW-1:0]   pickSel;
    logic             pickValid;
    logic [7:0]       dataByte [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_split
        assign dataByte[g] = data[8*g +: 8];
    end

    rr_pick #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .sel_o   (pickSel),
        .valid_o (pickValid)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(N_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            byte_q  <= '0;
            grant_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef UART_ARB_TAG_EN
            tag_q   <= 1'b0;
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            byte_q  <= byte_d;
            grant_q <= grant_d;
            count_q <= count_d;
            err_q   <= err_d;
`ifdef UART_ARB_TAG_EN
            tag_q   <= tag_d;
            hold_q  <= hold_d;
`endif
        end
    end

    // ack and tx_start are single-cycle pulses, so they default low every cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        start_d = 1'b0;
        byte_d  = byte_q;
        grant_d = grant_q;
        count_d = count_q;
        err_d   = err_q;
`ifdef UART_ARB_TAG_EN
        tag_d   = tag_q;
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    ack_d   = N_REQ'(1) << pickSel;
                    start_d = 1'b1;
                    grant_d = pickSel;
                    ptr_d   = pickSel;
                    cnt_d   = '0;
                    state_d = WAIT_BUSY;
`ifdef UART_ARB_TAG_EN
                    byte_d  = TAG_BASE | 8'(pickSel);
                    hold_d  = dataByte[pickSel];
                    tag_d   = 1'b1;
`else
                    byte_d  = dataByte[pickSel];
`endif
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
`ifdef UART_ARB_TAG_EN
                    tag_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_d = '0;
`ifdef UART_ARB_TAG_EN
                    if (tag_q) begin
                        tag_d   = 1'b0;
                        start_d = 1'b1;
                        byte_d  = hold_q;
                        state_d = WAIT_BUSY;
                    end else begin
                        count_d = count_q + 8'd1;
                        state_d = GAP;
                    end
`else
                    count_d = count_q + 8'd1;
                    state_d = GAP;
`endif
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack        = ack_q;
    assign tx_start   = start_q;
    assign tx_byte    = byte_q;
    assign grant_id   = grant_q;
    assign active     = (state_q != IDLE);
    assign byte_count = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple tx engine model.
// Runs the tag-byte scenario instead of the single-byte scenarios when UART_ARB_TAG_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 3;
    localparam int TMO = 8;

    logic         CLOCK_50 = 1'b0;
    logic         RESET;
    logic [N-1:0] req;
    logic [8*N-1:0] data;
    logic [N-1:0] ack;
    logic         tx_start;
    logic [7:0]   tx_byte;
    logic         tx_busy;
    logic [1:0]   grant_id;
    logic         active;
    logic [7:0]   byte_count;
    logic         err;

    int testCount = 0;
    int failCount = 0;
    int busyLen;
    logic engineOn;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .GAP_CYCLES     (GAP),
        .ACCEPT_TIMEOUT (TMO)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .byte_count (byte_count),
        .err        (err)
    );

    initial forever #5 CLOCK_50 = ~CLOCK_50;

    // Engine model: busy rises the cycle after tx_start and holds for busyLen cycles.
    initial begin
        int busyLeft;
        logic startSeen;
        tx_busy   = 1'b0;
        busyLeft  = 0;
        startSeen = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (startSeen) begin
                tx_busy   = 1'b1;
                busyLeft  = busyLen;
                startSeen = 1'b0;
            end else if (busyLeft > 0) begin
                busyLeft--;
                if (busyLeft == 0) tx_busy = 1'b0;
            end
            if (tx_start === 1'b1 && engineOn) startSeen = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [8*N-1:0] d);
        req  = r;
        data = d;
    endtask

    task automatic doReset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    task automatic waitAck(input int budget, output logic sawIdle);
        sawIdle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (active === 1'b0) sawIdle = 1'b1;
            if (ack !== '0) break;
        end
    endtask

    task automatic waitTxStart(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tx_start === 1'b1) break;
        end
    endtask

    task automatic waitByteCount(input logic [7:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (byte_count === target) break;
        end
    endtask

    task automatic waitActiveLow(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (active === 1'b0) break;
        end
    endtask

    initial begin
        logic sawIdle;
        logic held;
        logic ackOk;
        logic idleOk;
        int   order [6];
        logic [7:0] bytes [4];

        RESET    = 1'b1;
        engineOn = 1'b1;
        busyLen  = 2;
        applyStimulus('0, '0);
        tick();
        tick();
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_byte", tx_byte, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_byte_count", byte_count, 0);
        checkOutput("rst_err", err, 0);
        RESET = 1'b0;
        tick();

`ifdef UART_ARB_TAG_EN
        busyLen = 3;
        applyStimulus(4'b0010, {8'h44, 8'h33, 8'hC3, 8'h11});
        tick();
        checkOutput("tag_ack", ack, 4'b0010);
        checkOutput("tag_start1", tx_start, 1);
        checkOutput("tag_byte1", tx_byte, 8'hA1);
        checkOutput("tag_grant", grant_id, 1);
        applyStimulus('0, {8'h44, 8'h33, 8'hC3, 8'h11});
        waitTxStart(40);
        checkOutput("tag_start2", tx_start, 1);
        checkOutput("tag_byte2", tx_byte, 8'hC3);
        checkOutput("tag_ack_once", ack, 0);
        checkOutput("tag_count_mid", byte_count, 0);
        checkOutput("tag_active_mid", active, 1);
        held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx_start !== 1'b0 || ack !== '0) held = 1'b0;
            if (active === 1'b0) break;
        end
        checkOutput("tag_no_extra_pulse", held, 1);
        checkOutput("tag_count_end", byte_count, 1);
        checkOutput("tag_idle_end", active, 0);
        checkOutput("tag_err", err, 0);
`else
        // Single request with a long engine busy window.
        busyLen = 20;
        applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'h5A});
        tick();
        checkOutput("t1_ack", ack, 4'b0001);
        checkOutput("t1_tx_start", tx_start, 1);
        checkOutput("t1_tx_byte", tx_byte, 8'h5A);
        checkOutput("t1_grant_id", grant_id, 0);
        checkOutput("t1_active", active, 1);
        applyStimulus('0, {8'h44, 8'h33, 8'h22, 8'h5A});
        tick();
        checkOutput("t1_ack_pulse", ack, 0);
        checkOutput("t1_start_pulse", tx_start, 0);
        held = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_byte !== 8'h5A) held = 1'b0;
            if (byte_count === 8'd1) break;
        end
        checkOutput("t1_byte_held", held, 1);
        checkOutput("t1_count", byte_count, 1);
        applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'h66});
        tick();
        checkOutput("t1_gap_noack1", ack, 0);
        tick();
        checkOutput("t1_gap_noack2", ack, 0);
        checkOutput("t1_gap_active", active, 1);
        tick();
        checkOutput("t1_gap_noack3", ack, 0);
        checkOutput("t1_gap_idle", active, 0);
        tick();
        checkOutput("t1_regrant_ack", ack, 4'b0001);
        checkOutput("t1_regrant_byte", tx_byte, 8'h66);
        applyStimulus('0, {8'h44, 8'h33, 8'h22, 8'h66});
        waitByteCount(8'd2, 60);
        checkOutput("t1_count2", byte_count, 2);
        waitActiveLow(20);

        // Contention with requester 2 idle; pointer restarts from reset.
        doReset();
        busyLen = 2;
        order = '{0, 1, 3, 0, 1, 3};
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(4'b1011, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int g = 0; g < 6; g++) begin
            waitAck(40, sawIdle);
            checkOutput($sformatf("t2_ack_%0d", g), ack, 4'b0001 << order[g]);
            checkOutput($sformatf("t2_grant_%0d", g), grant_id, order[g]);
            checkOutput($sformatf("t2_byte_%0d", g), tx_byte, bytes[order[g]]);
        end
        applyStimulus('0, {8'h44, 8'h33, 8'h22, 8'h11});
        waitActiveLow(60);
        checkOutput("t2_count", byte_count, 6);

        // Engine never accepts: timeout sets err and skips the count.
        doReset();
        engineOn = 1'b0;
        applyStimulus(4'b0100, {8'h44, 8'h77, 8'h22, 8'h11});
        tick();
        checkOutput("t3_ack", ack, 4'b0100);
        checkOutput("t3_tx_start", tx_start, 1);
        applyStimulus('0, {8'h44, 8'h77, 8'h22, 8'h11});
        repeat (7) tick();
        checkOutput("t3_err_early", err, 0);
        tick();
        checkOutput("t3_err", err, 1);
        checkOutput("t3_count", byte_count, 0);
        checkOutput("t3_gap_active", active, 1);
        tick();
        tick();
        checkOutput("t3_gap_active2", active, 1);
        tick();
        checkOutput("t3_idle", active, 0);
        checkOutput("t3_err_sticky", err, 1);
        engineOn = 1'b1;

        // Asynchronous reset while the engine is mid-byte.
        busyLen = 20;
        applyStimulus(4'b1000, {8'h99, 8'h33, 8'h22, 8'h11});
        tick();
        checkOutput("t4_ack", ack, 4'b1000);
        repeat (4) tick();
        checkOutput("t4_busy_active", active, 1);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("t4_rst_active", active, 0);
        checkOutput("t4_rst_err", err, 0);
        checkOutput("t4_rst_byte", tx_byte, 0);
        checkOutput("t4_rst_grant", grant_id, 0);
        checkOutput("t4_rst_count", byte_count, 0);
        checkOutput("t4_rst_ack", ack, 0);
        checkOutput("t4_rst_start", tx_start, 0);
        applyStimulus(4'b1001, {8'h99, 8'h33, 8'h22, 8'h11});
        tick();
        RESET = 1'b0;
        tick();
        checkOutput("t4_first_ack", ack, 4'b0001);
        checkOutput("t4_first_byte", tx_byte, 8'h11);
        applyStimulus(4'b1000, {8'h99, 8'h33, 8'h22, 8'h11});
        waitAck(100, sawIdle);
        checkOutput("t4_second_ack", ack, 4'b1000);
        checkOutput("t4_second_byte", tx_byte, 8'h99);
        applyStimulus('0, {8'h99, 8'h33, 8'h22, 8'h11});
        waitActiveLow(100);

        // 256 back-to-back grants wrap the byte counter.
        doReset();
        busyLen = 1;
        ackOk   = 1'b1;
        idleOk  = 1'b1;
        applyStimulus(4'b0001, {8'h44, 8'h33, 8'h22, 8'h5A});
        for (int i = 0; i < 256; i++) begin
            waitAck(40, sawIdle);
            if (ack !== 4'b0001 || active !== 1'b1) ackOk = 1'b0;
            if (i > 0 && !sawIdle) idleOk = 1'b0;
            if (i == 255) checkOutput("t5_count_255", byte_count, 8'd255);
        end
        applyStimulus('0, {8'h44, 8'h33, 8'h22, 8'h5A});
        checkOutput("t5_acks", ackOk, 1);
        checkOutput("t5_idle_between", idleOk, 1);
        waitByteCount(8'd0, 40);
        checkOutput("t5_wrap", byte_count, 0);
        waitActiveLow(20);
        checkOutput("t5_idle_end", active, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
